// File: rtl/alu_normalize_if.sv
// rtl/alu_normalize_if.sv - request/result bundle for the normalize unit
interface alu_normalize_if;
    logic        start;
    logic [31:0] din;
    logic        sign_mode;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [4:0]  shamt;
    logic        zero;

    modport master (
        output start, din, sign_mode,
        input  busy, done, dout, shamt, zero
    );

    modport slave (
        input  start, din, sign_mode,
        output busy, done, dout, shamt, zero
    );
endinterface

// File: rtl/alu_normalize.sv
// rtl/alu_normalize.sv - iterative leading-zero / redundant-sign normalizer
module alu_normalize (
    input  logic           clk,
    input  logic           reset,
    alu_normalize_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic        mode_q, mode_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [2:0]  k_q, k_d;
    logic        zero_q, zero_d;

    logic [4:0]  step;
    logic        lz_ok;
    logic        rs_ok;
    logic        take;

    assign step = 5'd1 << k_q;

    // Logical stages need the top 2^k bits clear; arithmetic stages need the
    // top 2^k+1 bits identical so the sign survives the shift.
    always_comb begin
        lz_ok = 1'b0;
        rs_ok = 1'b0;
        case (k_q)
            3'd4: begin
                lz_ok = (work_q[31:16] == 16'h0000);
                rs_ok = (work_q[31:15] == 17'h00000) || (work_q[31:15] == 17'h1ffff);
            end
            3'd3: begin
                lz_ok = (work_q[31:24] == 8'h00);
                rs_ok = (work_q[31:23] == 9'h000) || (work_q[31:23] == 9'h1ff);
            end
            3'd2: begin
                lz_ok = (work_q[31:28] == 4'h0);
                rs_ok = (work_q[31:27] == 5'h00) || (work_q[31:27] == 5'h1f);
            end
            3'd1: begin
                lz_ok = (work_q[31:30] == 2'b00);
                rs_ok = (work_q[31:29] == 3'b000) || (work_q[31:29] == 3'b111);
            end
            3'd0: begin
                lz_ok = ~work_q[31];
                rs_ok = (work_q[31] == work_q[30]);
            end
            default: begin
                lz_ok = 1'b0;
                rs_ok = 1'b0;
            end
        endcase
    end

    assign take = mode_q ? rs_ok : lz_ok;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        shamt_d = shamt_q;
        k_d     = k_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.din;
                    mode_d  = bus.sign_mode;
                    shamt_d = 5'd0;
                    k_d     = 3'd4;
                    zero_d  = (bus.din == 32'h0000_0000);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (take) begin
                    work_d  = work_q << step;
                    shamt_d = shamt_q + step;
                end
                if (k_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            DONE: begin
                k_d     = 3'd4;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            work_q  <= 32'h0000_0000;
            mode_q  <= 1'b0;
            shamt_q <= 5'd0;
            k_q     <= 3'd4;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            shamt_q <= shamt_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.dout  = work_q;
    assign bus.shamt = shamt_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_alu_normalize.sv
// tb/tb_alu_normalize.sv - self-checking bench for alu_normalize
module tb_alu_normalize;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_normalize_if bus();

    alu_normalize dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic [4:0]  exp_shamt;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: count leading zeros, or leading bits matching the sign bit
    // beyond the sign itself, capped at 31.
    function automatic int ref_shamt(input logic m, input logic [31:0] d);
        int n;
        n = 0;
        if (!m) begin
            for (int i = 31; i >= 0; i--) begin
                if (d[i] == 1'b0) n++;
                else break;
            end
        end else begin
            for (int i = 30; i >= 0; i--) begin
                if (d[i] == d[31]) n++;
                else break;
            end
        end
        if (n > 31) n = 31;
        return n;
    endfunction

    task automatic do_op(input logic m, input logic [31:0] d,
                         output logic [31:0] o, output logic [4:0] s,
                         output logic z, output int lat);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.din       = d;
        bus.sign_mode = m;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.din       = $urandom;
        bus.sign_mode = ~m;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        o = bus.dout;
        s = bus.shamt;
        z = bus.zero;
    endtask

    task automatic run_check(input string tag, input logic m, input logic [31:0] d,
                             input logic [31:0] eo, input logic [4:0] es, input logic ez);
        logic [31:0] o;
        logic [4:0]  s;
        logic        z;
        int          lat;
        do_op(m, d, o, s, z, lat);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_dout"}, o, eo);
        chk({tag, "_shamt"}, {27'd0, s}, {27'd0, es});
        chk({tag, "_zero"}, {31'd0, z}, {31'd0, ez});
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] d, o, eo;
        logic [4:0]  s;
        logic        z, m;
        int          lat, es, dones;

        total = 0;
        bad   = 0;
        bus.start     = 1'b0;
        bus.din       = 32'h0;
        bus.sign_mode = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0};
        vecs[1] = '{1'b0, 32'h00F0_0000, 32'hF000_0000, 5'd8,  1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_8000, 32'h8000_0000, 5'd16, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0003, 32'h6000_0000, 5'd29, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1};

        reset = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_dout",  bus.dout,           32'd0);
        chk("rst_shamt", {27'd0, bus.shamt}, 32'd0);
        chk("rst_zero",  {31'd0, bus.zero},  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].din,
                      vecs[i].exp_dout, vecs[i].exp_shamt, vecs[i].exp_zero);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_hold_dout", i), bus.dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_hold_shamt", i), {27'd0, bus.shamt}, {27'd0, vecs[i].exp_shamt});
        end

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            d = $urandom >> $urandom_range(0, 31);
            if (m && $urandom_range(0, 1) == 1) d = ~d;
            es = ref_shamt(m, d);
            eo = d << es;
            run_check($sformatf("rnd%0d", i), m, d, eo, 5'(es), d == 32'h0);
        end

        // start held high for the whole operation: only the first operand counts
        @(negedge clk);
        bus.start = 1'b1; bus.din = 32'h0000_0F00; bus.sign_mode = 1'b0;
        @(posedge clk);
        dones = 0;
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            bus.din = $urandom; bus.sign_mode = 1'($urandom_range(0, 1));
            if (bus.done) dones++;
            lat++;
        end
        bus.start = 1'b0;
        chk("hold_start_dout",  bus.dout, 32'hF000_0000);
        chk("hold_start_shamt", {27'd0, bus.shamt}, 32'd20);
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("hold_start_dones", dones, 1);
        chk("hold_start_idle", {31'd0, bus.busy}, 32'd0);

        // reset in SCAN with k=2 aborts immediately
        @(negedge clk);
        bus.start = 1'b1; bus.din = 32'h0000_0001; bus.sign_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, bus.busy},  32'd0);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_dout",  bus.dout,           32'd0);
        chk("abort_shamt", {27'd0, bus.shamt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_check("after_abort", 1'b0, 32'h0000_4000, 32'h8000_0000, 5'd17, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
